decoder_8b10b: RTL

DECODER_8B10B -- requirements
Module: decoder_8b10b

---
 rtl/decoder_8b10b_pkg.sv | 30 +++
 rtl/decoder_8b10b_lut.sv | 141 ++++++++++++++
 rtl/decoder_8b10b.sv | 118 +++++++++++
 3 files changed

// File: rtl/decoder_8b10b_pkg.sv
// Shared 8b/10b definitions: word-sync states, comma patterns, K28.5 constants
// and disparity encodings used by both the encoder and the decoder.
package decoder_8b10b_pkg;

  typedef enum logic [1:0] {
    LOSS_SYNC = 2'd0,
    ACQ1      = 2'd1,
    ACQ2      = 2'd2,
    SYNC      = 2'd3
  } sync_state_t;

  // Comma patterns as seen on bits f i e d c b a (entradas[6:0])
  localparam logic [6:0] COMMA_NEG = 7'b1111100;
  localparam logic [6:0] COMMA_POS = 7'b0000011;

  localparam logic [7:0] K28_5_BYTE = 8'hBC;
  localparam logic [9:0] K28_5_RDN  = 10'h17C;
  localparam logic [9:0] K28_5_RDP  = 10'h283;

  // Sub-block disparities are carried as 4-bit two's complement values
  localparam logic [3:0] DISP_P2 = 4'b0010;
  localparam logic [3:0] DISP_M2 = 4'b1110;

  localparam logic [15:0] ERRCNT_MAX = 16'hFFFF;

  function automatic logic is_comma(input logic [6:0] low7);
    return (low7 == COMMA_NEG) || (low7 == COMMA_POS);
  endfunction

endpackage

// File: rtl/decoder_8b10b_lut.sv
// Combinational 8b/10b table lookup: splits a code group into abcdei/fghj,
// decodes both sub-blocks and reports disparities and column restrictions.
module decoder_8b10b_lut
  import decoder_8b10b_pkg::*;
(
  input  logic [9:0] code,
  output logic [7:0] data,
  output logic       k,
  output logic       invalid,
  output logic [3:0] disp6,
  output logic [3:0] disp4,
  output logic       neg_only6,
  output logic       pos_only6,
  output logic       neg_only4,
  output logic       pos_only4
);

  logic [5:0] six;
  logic [3:0] four;
  logic [3:0] four_n;
  logic [4:0] x;
  logic [2:0] y;
  logic [2:0] ones6;
  logic [2:0] ones4;
  logic       v6;
  logic       v4;
  logic       k28;
  logic       kx7;
  logic       a7;
  logic       p7;
  logic       bad_disp;
  logic       kflag;

  assign six  = {code[0], code[1], code[2], code[3], code[4], code[5]};
  assign four = {code[6], code[7], code[8], code[9]};

  always_comb begin
    ones6 = 3'd0;
    ones4 = 3'd0;
    for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, six[i]};
    for (int i = 0; i < 4; i++) ones4 = ones4 + {2'b00, four[i]};
  end

  assign disp6 = ({1'b0, ones6} << 1) - 4'd6;
  assign disp4 = ({1'b0, ones4} << 1) - 4'd4;

  always_comb begin
    x   = 5'd0;
    v6  = 1'b1;
    k28 = 1'b0;
    case (six)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      6'b001111, 6'b110000: begin
        x   = 5'd28;
        k28 = 1'b1;
      end
      default: v6 = 1'b0;
    endcase
  end

  // K28 at RD+ sends the complement of its RD- fghj, so undo that before lookup
  assign four_n = (six == 6'b110000) ? ~four : four;

  always_comb begin
    y  = 3'd0;
    v4 = 1'b1;
    a7 = 1'b0;
    p7 = 1'b0;
    case (four_n)
      4'b1011, 4'b0100: y = 3'd0;
      4'b1001:          y = 3'd1;
      4'b0101:          y = 3'd2;
      4'b1100, 4'b0011: y = 3'd3;
      4'b1101, 4'b0010: y = 3'd4;
      4'b1010:          y = 3'd5;
      4'b0110:          y = 3'd6;
      4'b1110, 4'b0001: begin
        y  = 3'd7;
        p7 = 1'b1;
      end
      4'b0111, 4'b1000: begin
        y  = 3'd7;
        a7 = 1'b1;
      end
      default: v4 = 1'b0;
    endcase
  end

  always_comb begin
    kx7 = 1'b0;
    case (six)
      6'b111010, 6'b000101, 6'b110110, 6'b001001,
      6'b101110, 6'b010001, 6'b011110, 6'b100001: kx7 = 1'b1;
      default: kx7 = 1'b0;
    endcase
  end

  assign bad_disp = !(disp6 inside {4'd0, DISP_P2, DISP_M2}) ||
                    !(disp4 inside {4'd0, DISP_P2, DISP_M2});
  assign invalid  = !v6 || !v4 || (k28 && p7) || bad_disp;
  assign kflag    = k28 || (kx7 && a7);
  assign data     = invalid ? 8'h00 : {y, x};
  assign k        = !invalid && kflag;

  assign neg_only6 = (disp6 == DISP_P2) || (six == 6'b111000);
  assign pos_only6 = (disp6 == DISP_M2) || (six == 6'b000111);
  assign neg_only4 = (disp4 == DISP_P2) || (four == 4'b1100);
  assign pos_only4 = (disp4 == DISP_M2) || (four == 4'b0011);

endmodule

// File: rtl/decoder_8b10b.sv
// 8b/10b decoder with running-disparity tracking and word-sync FSM.
// Optional DECODER_ERRCNT_EN adds a saturating 16-bit errored-group counter.
module decoder_8b10b
  import decoder_8b10b_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic [9:0] entradas,
  output logic [7:0] salidas,
  output logic       K,
  output logic       valid,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd,
  output logic       sync
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  sync_state_t state;
  logic [1:0]  err_run;
  logic [7:0]  lut_data;
  logic        lut_k;
  logic        lut_invalid;
  logic [3:0]  disp6;
  logic [3:0]  disp4;
  logic        neg_only6;
  logic        pos_only6;
  logic        neg_only4;
  logic        pos_only4;
  logic        rd_mid;
  logic        rd_next;
  logic        derr;
  logic        bad;
  logic        comma;

  decoder_8b10b_lut u_lut (
    .code      (entradas),
    .data      (lut_data),
    .k         (lut_k),
    .invalid   (lut_invalid),
    .disp6     (disp6),
    .disp4     (disp4),
    .neg_only6 (neg_only6),
    .pos_only6 (pos_only6),
    .neg_only4 (neg_only4),
    .pos_only4 (pos_only4)
  );

  // The 6b sub-block is checked against the incoming RD, the 4b one against the RD it leaves
  always_comb begin
    rd_mid  = (disp6 == DISP_P2) ? 1'b1 : (disp6 == DISP_M2) ? 1'b0 : rd;
    rd_next = (disp4 == DISP_P2) ? 1'b1 : (disp4 == DISP_M2) ? 1'b0 : rd_mid;
    derr    = (rd ? neg_only6 : pos_only6) | (rd_mid ? neg_only4 : pos_only4);
    bad     = lut_invalid | derr;
    comma   = is_comma(entradas[6:0]);
  end

  assign sync = (state == SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      salidas  <= 8'h00;
      K        <= 1'b0;
      valid    <= 1'b0;
      code_err <= 1'b0;
      disp_err <= 1'b0;
      rd       <= 1'b0;
      state    <= LOSS_SYNC;
      err_run  <= 2'd0;
    end else if (enb) begin
      salidas  <= lut_data;
      K        <= lut_k;
      valid    <= 1'b1;
      code_err <= lut_invalid;
      disp_err <= derr;
      rd       <= rd_next;
      case (state)
        LOSS_SYNC: if (comma && !bad) state <= ACQ1;
        ACQ1: begin
          if (bad)        state <= LOSS_SYNC;
          else if (comma) state <= ACQ2;
        end
        ACQ2: begin
          if (bad)        state <= LOSS_SYNC;
          else if (comma) state <= SYNC;
        end
        SYNC: begin
          if (!bad) begin
            err_run <= 2'd0;
          end else if (err_run == 2'd3) begin
            err_run <= 2'd0;
            state   <= LOSS_SYNC;
          end else begin
            err_run <= err_run + 2'd1;
          end
        end
        default: state <= LOSS_SYNC;
      endcase
    end else begin
      valid <= 1'b0;
    end
  end

`ifdef DECODER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 16'h0000;
    end else if (enb && bad && (err_cnt != ERRCNT_MAX)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
